// File: rtl/iq_gen_deadlock_watchdog.sv
// Deadlock watchdog for the iq_gen core: qualifies monitor stalls, latches the
// blocked streams, raises a sticky interrupt and optionally sequences a core
// reset followed by a hold-off window.
module iq_gen_deadlock_watchdog #(
   parameter int unsigned N_AXIS         = 3,
   parameter int unsigned TIMEOUT_W      = 16,
   parameter int unsigned RST_CYCLES     = 16,
   parameter int unsigned HOLDOFF_CYCLES = 16
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  block,
   input  logic [3*N_AXIS-1:0]   axis_block_info,
   input  logic                  inst_idle,
   input  logic                  enable,
   input  logic                  recover_en,
   input  logic [TIMEOUT_W-1:0]  timeout,
   input  logic                  clear,
   output logic                  core_rst_n,
   output logic                  irq,
   output logic [N_AXIS-1:0]     blocked_mask,
   output logic [7:0]            event_count,
   output logic [2:0]            state
);

   localparam int unsigned CNT_W  = TIMEOUT_W + 1;
   localparam int unsigned PH_MAX = (RST_CYCLES > HOLDOFF_CYCLES) ? RST_CYCLES : HOLDOFF_CYCLES;
   localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam int unsigned EVT_W  = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARMED    = 3'd1,
      ST_COUNT    = 3'd2,
      ST_DEADLOCK = 3'd3,
      ST_RECOVER  = 3'd4,
      ST_HOLDOFF  = 3'd5
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [TIMEOUT_W-1:0]   cnt_q;
   logic [TIMEOUT_W-1:0]   cnt_d;
   logic [PH_W-1:0]        ph_q;
   logic [PH_W-1:0]        ph_d;
   logic                   abort_q;
   logic                   abort_d;
   logic                   irq_d;
   logic [N_AXIS-1:0]      mask_d;
   logic [EVT_W-1:0]       evt_d;
   logic                   core_rst_n_d;

   logic [N_AXIS-1:0]      chan;
   logic                   qual;
   logic [TIMEOUT_W-1:0]   t_eff;
   logic [CNT_W-1:0]       cnt_inc;
   logic                   hit;
   logic [TIMEOUT_W-1:0]   cnt_sat_next;
   logic                   enter_dl;

   // Per-channel blocked decode: any nonzero 3-bit field marks the channel.
   always_comb begin
      chan = '0;
      for (int i = 0; i < int'(N_AXIS); i++) begin
         chan[i] = |axis_block_info[3*i +: 3];
      end
   end

   // Qualification and timeout comparison; a zero timeout behaves as one.
   always_comb begin
      qual         = block & ~inst_idle;
      t_eff        = (timeout == '0) ? TIMEOUT_W'(1) : timeout;
      cnt_inc      = {1'b0, cnt_q} + CNT_W'(1);
      hit          = (cnt_inc >= {1'b0, t_eff});
      cnt_sat_next = (&cnt_q) ? cnt_q : cnt_q + TIMEOUT_W'(1);
   end

   // Next-state logic and internal counter updates.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ph_d     = ph_q;
      abort_d  = abort_q;
      enter_dl = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (enable) begin
               state_d = ST_ARMED;
            end
         end

         ST_ARMED: begin
            cnt_d = '0;
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (qual) begin
               if (t_eff == TIMEOUT_W'(1)) begin
                  state_d  = ST_DEADLOCK;
                  enter_dl = 1'b1;
               end else begin
                  state_d = ST_COUNT;
                  cnt_d   = TIMEOUT_W'(1);
               end
            end
         end

         ST_COUNT: begin
            if (!enable) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (qual) begin
               if (hit) begin
                  state_d  = ST_DEADLOCK;
                  enter_dl = 1'b1;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_sat_next;
               end
            end else begin
               state_d = ST_ARMED;
               cnt_d   = '0;
            end
         end

         ST_DEADLOCK: begin
            cnt_d = '0;
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (recover_en) begin
               state_d = ST_RECOVER;
               ph_d    = '0;
               abort_d = 1'b0;
            end else if (clear) begin
               state_d = ST_ARMED;
            end
         end

         // Reset pulse always runs to completion; a disable seen anywhere
         // during the pulse redirects the exit to IDLE.
         ST_RECOVER: begin
            if (!enable) begin
               abort_d = 1'b1;
            end
            if (ph_q == PH_W'(RST_CYCLES - 1)) begin
               ph_d = '0;
               if (abort_q || !enable) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HOLDOFF;
               end
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end

         ST_HOLDOFF: begin
            if (!enable) begin
               state_d = ST_IDLE;
               ph_d    = '0;
            end else if (ph_q == PH_W'(HOLDOFF_CYCLES - 1)) begin
               state_d = ST_ARMED;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ph_d    = '0;
            abort_d = 1'b0;
         end
      endcase
   end

   // Status outputs: clear wipes the sticky bits, a coincident detection wins.
   always_comb begin
      irq_d  = irq;
      mask_d = blocked_mask;
      evt_d  = event_count;
      if (clear) begin
         irq_d  = 1'b0;
         mask_d = '0;
      end
      if (enter_dl) begin
         irq_d  = 1'b1;
         mask_d = mask_d | chan;
         evt_d  = (&event_count) ? event_count : event_count + EVT_W'(1);
      end
      core_rst_n_d = (state_d != ST_RECOVER);
   end

   // State and counter registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ph_q    <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ph_q    <= ph_d;
         abort_q <= abort_d;
      end
   end

   // Registered outputs; reset releases the core immediately.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         core_rst_n   <= 1'b1;
         irq          <= 1'b0;
         blocked_mask <= '0;
         event_count  <= '0;
      end else begin
         core_rst_n   <= core_rst_n_d;
         irq          <= irq_d;
         blocked_mask <= mask_d;
         event_count  <= evt_d;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_iq_gen_deadlock_watchdog.sv
// Self-checking bench for iq_gen_deadlock_watchdog: directed vector table,
// multi-cycle corner sequences and randomized traffic against a reference model.
module tb_iq_gen_deadlock_watchdog;

   localparam int N_AXIS   = 3;
   localparam int TW       = 16;
   localparam int RST_CYC  = 16;
   localparam int HOLD_CYC = 16;

   // Spec state codes; the model merges ARMED/COUNT into one watching mode.
   localparam int S_IDLE = 0, S_ARMED = 1, S_COUNT = 2, S_DL = 3, S_REC = 4, S_HOLD = 5;
   localparam int M_IDLE = 0, M_WATCH = 1, M_DL = 3, M_REC = 4, M_HOLD = 5;

   logic                ap_clk = 1'b0;
   logic                ap_rst_n;
   logic                block;
   logic [3*N_AXIS-1:0] axis_block_info;
   logic                inst_idle;
   logic                enable;
   logic                recover_en;
   logic [TW-1:0]       timeout;
   logic                clear;
   logic                core_rst_n;
   logic                irq;
   logic [N_AXIS-1:0]   blocked_mask;
   logic [7:0]          event_count;
   logic [2:0]          state;

   int tests    = 0;
   int failures = 0;

   // Reference model state
   int m_mode, m_run, m_timer, m_irq, m_mask, m_evt;
   bit m_abort;

   iq_gen_deadlock_watchdog #(
      .N_AXIS(N_AXIS), .TIMEOUT_W(TW), .RST_CYCLES(RST_CYC), .HOLDOFF_CYCLES(HOLD_CYC)
   ) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .block(block),
      .axis_block_info(axis_block_info), .inst_idle(inst_idle), .enable(enable),
      .recover_en(recover_en), .timeout(timeout), .clear(clear),
      .core_rst_n(core_rst_n), .irq(irq), .blocked_mask(blocked_mask),
      .event_count(event_count), .state(state)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int chan_of(input logic [3*N_AXIS-1:0] info);
      int m = 0;
      for (int i = 0; i < N_AXIS; i++) begin
         if (((info >> (3 * i)) & 7) != 0) m |= (1 << i);
      end
      return m;
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_run = 0; m_timer = 0; m_abort = 0;
      m_irq = 0; m_mask = 0; m_evt = 0;
   endtask

   // One clock edge of behaviour, from the current (pre-edge) inputs.
   task automatic model_step();
      int t;
      bit q;
      bit enter;
      t     = (timeout == 0) ? 1 : int'(timeout);
      q     = block && !inst_idle;
      enter = 0;
      case (m_mode)
         M_IDLE: begin
            m_run = 0;
            if (enable) m_mode = M_WATCH;
         end
         M_WATCH: begin
            if (!enable) begin
               m_mode = M_IDLE; m_run = 0;
            end else if (q) begin
               m_run++;
               if (m_run >= t) begin
                  enter = 1; m_mode = M_DL; m_run = 0;
               end
            end else begin
               m_run = 0;
            end
         end
         M_DL: begin
            if (!enable) m_mode = M_IDLE;
            else if (recover_en) begin
               m_mode = M_REC; m_timer = RST_CYC; m_abort = 0;
            end else if (clear) m_mode = M_WATCH;
         end
         M_REC: begin
            if (!enable) m_abort = 1;
            m_timer--;
            if (m_timer == 0) begin
               if (m_abort) m_mode = M_IDLE;
               else begin
                  m_mode = M_HOLD; m_timer = HOLD_CYC;
               end
            end
         end
         default: begin
            if (!enable) m_mode = M_IDLE;
            else begin
               m_timer--;
               if (m_timer == 0) begin
                  m_mode = M_WATCH; m_run = 0;
               end
            end
         end
      endcase
      if (clear) begin
         m_irq = 0; m_mask = 0;
      end
      if (enter) begin
         m_irq  = 1;
         m_mask = m_mask | chan_of(axis_block_info);
         m_evt  = (m_evt < 255) ? m_evt + 1 : 255;
      end
   endtask

   function automatic int model_state();
      if (m_mode == M_WATCH) return (m_run > 0) ? S_COUNT : S_ARMED;
      return m_mode;
   endfunction

   // Advance one cycle and compare every output with the model.
   task automatic tick();
      @(posedge ap_clk);
      model_step();
      #1;
      check("model_state", state, model_state());
      check("model_irq", irq, m_irq);
      check("model_mask", blocked_mask, m_mask);
      check("model_evt", event_count, m_evt);
      check("model_core_rst_n", core_rst_n, (m_mode == M_REC) ? 0 : 1);
   endtask

   task automatic do_reset();
      ap_rst_n = 1'b0;
      block = 0; axis_block_info = '0; inst_idle = 0; enable = 0;
      recover_en = 0; timeout = '0; clear = 0;
      model_reset();
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
   endtask

   typedef struct {
      logic          en;
      logic          rec;
      logic [TW-1:0] to;
      logic          blk;
      logic [8:0]    info;
      logic          idle;
      logic          clr;
      int            st;
      int            irq;
      int            mask;
      int            evt;
      int            crst;
   } vec_t;

   vec_t vecs[18];

   task automatic set_vec(input int i, input logic en, input logic rec, input int to,
                          input logic blk, input logic [8:0] info, input logic idle,
                          input logic clr, input int st, input int ir, input int mk,
                          input int ev, input int cr);
      vecs[i].en = en; vecs[i].rec = rec; vecs[i].to = TW'(to); vecs[i].blk = blk;
      vecs[i].info = info; vecs[i].idle = idle; vecs[i].clr = clr;
      vecs[i].st = st; vecs[i].irq = ir; vecs[i].mask = mk; vecs[i].evt = ev; vecs[i].crst = cr;
   endtask

   initial begin
      int low, hold, found;

      //           i  en rec to blk info    idle clr | st   irq mask evt crst
      set_vec( 0, 1, 0, 4, 0, 9'h000, 0, 0, S_ARMED, 0, 0, 0, 1);
      set_vec( 1, 1, 0, 4, 1, 9'h006, 0, 0, S_COUNT, 0, 0, 0, 1);
      set_vec( 2, 1, 0, 4, 1, 9'h006, 0, 0, S_COUNT, 0, 0, 0, 1);
      set_vec( 3, 1, 0, 4, 1, 9'h006, 0, 0, S_COUNT, 0, 0, 0, 1);
      set_vec( 4, 1, 0, 4, 0, 9'h006, 0, 0, S_ARMED, 0, 0, 0, 1);
      set_vec( 5, 1, 0, 4, 1, 9'h006, 0, 0, S_COUNT, 0, 0, 0, 1);
      set_vec( 6, 1, 0, 4, 1, 9'h006, 0, 0, S_COUNT, 0, 0, 0, 1);
      set_vec( 7, 1, 0, 4, 1, 9'h006, 0, 0, S_COUNT, 0, 0, 0, 1);
      set_vec( 8, 1, 0, 4, 1, 9'h006, 0, 0, S_DL,    1, 1, 1, 1);
      set_vec( 9, 1, 0, 4, 1, 9'h006, 0, 0, S_DL,    1, 1, 1, 1);
      set_vec(10, 1, 0, 4, 1, 9'h006, 0, 1, S_ARMED, 0, 0, 1, 1);
      set_vec(11, 1, 0, 4, 1, 9'h006, 0, 0, S_COUNT, 0, 0, 1, 1);
      set_vec(12, 1, 0, 4, 0, 9'h006, 0, 0, S_ARMED, 0, 0, 1, 1);
      set_vec(13, 1, 0, 0, 1, 9'h038, 0, 0, S_DL,    1, 2, 2, 1);
      set_vec(14, 1, 0, 0, 0, 9'h000, 0, 1, S_ARMED, 0, 0, 2, 1);
      set_vec(15, 1, 0, 0, 1, 9'h000, 1, 0, S_ARMED, 0, 0, 2, 1);
      set_vec(16, 1, 0, 0, 1, 9'h000, 1, 0, S_ARMED, 0, 0, 2, 1);
      set_vec(17, 0, 0, 0, 0, 9'h000, 0, 0, S_IDLE,  0, 0, 2, 1);

      // Reset values
      do_reset();
      #1;
      check("reset_state", state, S_IDLE);
      check("reset_irq", irq, 0);
      check("reset_mask", blocked_mask, 0);
      check("reset_evt", event_count, 0);
      check("reset_core_rst_n", core_rst_n, 1);

      // Directed vector table
      for (int i = 0; i < 18; i++) begin
         enable = vecs[i].en; recover_en = vecs[i].rec; timeout = vecs[i].to;
         block = vecs[i].blk; axis_block_info = vecs[i].info;
         inst_idle = vecs[i].idle; clear = vecs[i].clr;
         tick();
         check($sformatf("vec%0d_state", i), state, vecs[i].st);
         check($sformatf("vec%0d_irq", i), irq, vecs[i].irq);
         check($sformatf("vec%0d_mask", i), blocked_mask, vecs[i].mask);
         check($sformatf("vec%0d_evt", i), event_count, vecs[i].evt);
         check($sformatf("vec%0d_core_rst_n", i), core_rst_n, vecs[i].crst);
      end

      // Recovery: pulse width, hold-off length, then re-detection
      do_reset();
      enable = 1; recover_en = 1; timeout = TW'(2); axis_block_info = 9'h001;
      tick();
      block = 1;
      low = 0; hold = 0; found = 0;
      for (int k = 0; k < 100 && found == 0; k++) begin
         tick();
         if (!core_rst_n) low++;
         if (state == 3'(S_HOLD)) hold++;
         if (event_count == 8'd2) found = 1;
      end
      check("rec_redetect", found, 1);
      check("rec_pulse_len", low, RST_CYC);
      check("rec_holdoff_len", hold, HOLD_CYC);
      check("rec_irq", irq, 1);

      // Disable during the reset pulse: full pulse, then IDLE
      do_reset();
      enable = 1; recover_en = 1; timeout = TW'(1); block = 1; axis_block_info = 9'h008;
      tick();
      low = 0;
      for (int k = 0; k < 60; k++) begin
         if (low == 5) enable = 0;
         tick();
         if (!core_rst_n) low++;
         else if (low > 0) break;
      end
      check("abort_pulse_len", low, RST_CYC);
      check("abort_state", state, S_IDLE);

      // Asynchronous reset in the middle of the reset pulse
      do_reset();
      enable = 1; recover_en = 1; timeout = TW'(1); block = 1; axis_block_info = 9'h040;
      repeat (5) tick();
      check("arst_pre_core_rst_n", core_rst_n, 0);
      #2;
      ap_rst_n = 1'b0;
      #1;
      check("arst_core_rst_n", core_rst_n, 1);
      check("arst_state", state, S_IDLE);
      check("arst_irq", irq, 0);
      check("arst_mask", blocked_mask, 0);
      check("arst_evt", event_count, 0);

      // inst_idle suppresses qualification; zero timeout detects at once
      do_reset();
      enable = 1; timeout = TW'(3); inst_idle = 1; block = 1; axis_block_info = 9'h1FF;
      repeat (100) tick();
      check("idle_irq", irq, 0);
      check("idle_state", state, S_ARMED);
      check("idle_evt", event_count, 0);
      inst_idle = 0; timeout = '0;
      tick();
      check("t0_state", state, S_DL);
      check("t0_mask", blocked_mask, 7);

      // Event counter saturation and coincident clear/detection
      do_reset();
      enable = 1; timeout = '0; block = 1; axis_block_info = 9'h040;
      tick();
      for (int k = 0; k < 260; k++) begin
         clear = 0; tick();
         clear = 1; tick();
      end
      clear = 0;
      check("sat_evt", event_count, 255);
      axis_block_info = 9'h1C0;
      tick();
      check("sat_evt_hold", event_count, 255);
      enable = 0; tick();
      enable = 1; block = 0; tick();
      check("sticky_mask", blocked_mask, 4);
      block = 1; axis_block_info = 9'h001; clear = 1;
      tick();
      clear = 0;
      check("coincide_state", state, S_DL);
      check("coincide_irq", irq, 1);
      check("coincide_mask", blocked_mask, 1);

      // Randomized traffic against the model
      do_reset();
      enable = 1; recover_en = 0; timeout = TW'(3);
      for (int k = 0; k < 3000; k++) begin
         block           = ($urandom_range(0, 9) < 7);
         inst_idle       = ($urandom_range(0, 9) == 0);
         axis_block_info = 9'($urandom_range(0, 511));
         clear           = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 49) == 0) enable = ~enable;
         if (!enable && $urandom_range(0, 3) == 0) enable = 1;
         if ($urandom_range(0, 29) == 0) recover_en = ~recover_en;
         if ($urandom_range(0, 19) == 0) timeout = TW'($urandom_range(0, 5));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/iq_gen_deadlock_watchdog.md
# iq_gen_deadlock_watchdog

Watchdog controller for the iq_gen HLS core. It consumes the deadlock monitor's `block` flag and its per-AXIS `axis_block_info` fields. It qualifies a stall only after a programmable number of consecutive cycles, then latches which streams were blocked and raises a sticky interrupt. Optionally it sequences a recovery: an active-low reset pulse to the core, followed by a hold-off window. It sits between the monitor and the control/status register block.

## Interface
- `N_AXIS`, 3: number of monitored AXI-stream channels; `axis_block_info` carries 3 bits per channel.
- `TIMEOUT_W`, 16: width of the timeout counter and its config value.
- `RST_CYCLES`, 16: length of the core reset pulse, in cycles.
- `HOLDOFF_CYCLES`, 16: cycles after recovery during which `block` is ignored.

Ports:
- `ap_clk` in 1: single clock for the block.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `block` in 1: registered deadlock flag from the monitor.
- `axis_block_info` in 3*N_AXIS: field i is bits [3i+2:3i]; a nonzero field means channel i is blocked.
- `inst_idle` in 1: core idle; suspends qualification.
- `enable` in 1: level; arms the watchdog.
- `recover_en` in 1: level; selects automatic recovery.
- `timeout` in TIMEOUT_W: number of qualifying cycles before a deadlock is declared; 0 is treated as 1.
- `clear` in 1: single-cycle pulse; clears `irq`, `blocked_mask` and the DEADLOCK state.
- `core_rst_n` out 1: active-low reset to the iq_gen core.
- `irq` out 1: sticky deadlock interrupt.
- `blocked_mask` out N_AXIS: sticky OR of the channels blocked at detection.
- `event_count` out 8: deadlock events, saturating at 255.
- `state` out 3: FSM state, for status readback.

## Operation
- A qualifying cycle is one where `block`=1 and `inst_idle`=0.
- Per-channel decode: `chan[i]` = OR-reduction of field i.

FSM states and encoding: IDLE=0, ARMED=1, COUNT=2, DEADLOCK=3, RECOVER=4, HOLDOFF=5.
- IDLE: counter is 0. If `enable`=1, go to ARMED.
- ARMED: on a qualifying cycle, go to COUNT with cnt=1. If that cycle also reaches the effective timeout (timeout ≤ 1), go directly to DEADLOCK.
- COUNT: on a qualifying cycle, cnt+1. When cnt+1 ≥ max(timeout,1), go to DEADLOCK. On a non-qualifying cycle, cnt=0 and go to ARMED.
- Entry to DEADLOCK:
  - `irq` is set.
  - `blocked_mask` |= `chan`.
  - `event_count` increments, saturating at 255.
  - cnt=0.
- DEADLOCK: if `recover_en`=1, go to RECOVER on the next cycle. Otherwise remain until `clear`, then go to ARMED.
- RECOVER: `core_rst_n`=0 for exactly RST_CYCLES cycles, then go to HOLDOFF.
- HOLDOFF: `block` is ignored for HOLDOFF_CYCLES cycles, then go to ARMED.
- `enable`=0:
  - From ARMED, COUNT, DEADLOCK or HOLDOFF: go to IDLE next cycle.
  - From RECOVER: the reset pulse completes in full, then go to IDLE rather than HOLDOFF.
- `clear`:
  - Clears `irq` and `blocked_mask` in any state.
  - Does not affect `event_count`.
  - If a new DEADLOCK entry coincides with `clear`, the set wins: `irq`=1 and mask = current `chan`.
- The timeout counter saturates and never wraps. Changing `timeout` mid-count takes effect on the next comparison.

## Timing
- Reset values: `state`=IDLE, `core_rst_n`=1, `irq`=0, `blocked_mask`=0, `event_count`=0, internal counters 0.
- All outputs are registered; there is no combinational input-to-output path.
- Detection latency: with T = max(timeout,1), DEADLOCK is entered on the edge that samples the T-th consecutive qualifying cycle. `irq` is visible in the cycle after that edge.
- `core_rst_n` falls on the edge after DEADLOCK entry and is low for exactly RST_CYCLES cycles.
- After `core_rst_n` rises, ARMED is re-entered HOLDOFF_CYCLES cycles later.
- Asserting `ap_rst_n` mid-recovery immediately forces `core_rst_n`=1 and returns the block to IDLE.

## Test plan
- timeout=4, enable=1, `block` high for 3 cycles then low -> no `irq`, state returns to ARMED, `event_count`=0.
- timeout=4, `block` high for 6 cycles with `axis_block_info`=9'h006 -> `irq`=1 one cycle after the 4th sample, `blocked_mask`=3'b001, `event_count`=1. `clear` -> `irq`=0, mask=0, state=ARMED.
- recover_en=1, timeout=2, `block` held high throughout -> `core_rst_n` low for exactly 16 cycles, then 16 HOLDOFF cycles with no re-detection, then redetect; `event_count`=2.
- `inst_idle`=1 with `block`=1 for 100 cycles -> no detection. timeout=0 with a single qualifying cycle -> DEADLOCK.
- 260 deadlock/clear cycles -> `event_count` saturates at 255. `clear` on the same cycle as DEADLOCK entry -> `irq`=1.
- `enable` drops 5 cycles into RECOVER -> pulse still lasts 16 cycles, then IDLE. `ap_rst_n` asserted mid-RECOVER -> `core_rst_n`=1 asynchronously and all outputs at reset values.
